// File: rtl/video_timing_pkg.sv
// video_timing_pkg: shared types, default raster timing and vertical scaling helper for
// video_timing_gen and its sub-modules.
package video_timing_pkg;

    // Line-count standard held in the mode latch.
    typedef enum logic {
        MODE_NTSC = 1'b0,
        MODE_PAL  = 1'b1
    } vtg_mode_e;

    // Default horizontal timing, in pixels.
    localparam int unsigned DEF_HCW      = 10;
    localparam int unsigned DEF_VCW      = 10;
    localparam int unsigned DEF_CE_DIV   = 2;
    localparam int unsigned DEF_H_TOTAL  = 638;
    localparam int unsigned DEF_H_ACTIVE = 529;
    localparam int unsigned DEF_HS_START = 544;
    localparam int unsigned DEF_HS_END   = 590;

    // Default vertical timing, in native (not scan-doubled) lines.
    localparam int unsigned DEF_V_TOTAL_NTSC  = 262;
    localparam int unsigned DEF_V_ACTIVE_NTSC = 240;
    localparam int unsigned DEF_VS_START_NTSC = 245;
    localparam int unsigned DEF_VS_END_NTSC   = 248;
    localparam int unsigned DEF_V_TOTAL_PAL   = 312;
    localparam int unsigned DEF_V_ACTIVE_PAL  = 300;
    localparam int unsigned DEF_VS_START_PAL  = 304;
    localparam int unsigned DEF_VS_END_PAL    = 308;

    // Scan-doubled modes draw every native line twice, so every vertical limit doubles.
    function automatic int unsigned scale_v(input int unsigned value, input logic sd);
        return sd ? (value << 1) : value;
    endfunction

endpackage

// File: rtl/vtg_ce_div.sv
// vtg_ce_div: pixel clock-enable divider.
//   clk     in   system clock
//   reset   in   asynchronous, active-high
//   restart in   synchronous phase restart (phase returns to 0 on this edge)
//   bypass  in   1 = enable every clk
//   ce      out  registered clock-enable, one clk high every CE_DIV clks
module vtg_ce_div
    import video_timing_pkg::*;
#(
    parameter int unsigned CE_DIV = DEF_CE_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    input  logic bypass,
    output logic ce
);

    localparam int unsigned PW = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(CE_DIV - 1);

    logic [PW-1:0] phase_q, phase_d;
    logic          ce_q, ce_d;

    // ce_q is high exactly while phase_q sits at PHASE_LAST, so a restart issued on an
    // enable cycle lands on phase 0 just like a normal wrap and the cadence is unbroken.
    always_comb begin
        phase_d = phase_q + 1'b1;
        if (restart || phase_q == PHASE_LAST) begin
            phase_d = '0;
        end
        ce_d = bypass | (phase_d == PHASE_LAST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q <= '0;
            ce_q    <= 1'b0;
        end else begin
            phase_q <= phase_d;
            ce_q    <= ce_d;
        end
    end

    assign ce = ce_q;

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: parametrised NTSC/PAL raster timing generator, native or scan-doubled.
//   clk          in   system clock
//   reset        in   asynchronous, active-high
//   pal          in   1 = PAL line counts, 0 = NTSC (sampled only at frame wrap)
//   scandouble   in   1 = doubled line counts, one pixel per clk (sampled only at frame wrap)
//   ce_pix       out  pixel clock-enable
//   hc / vc      out  current pixel / line
//   HBlank, HSync, VBlank, VSync  out  registered strobes; syncs active at HS_POL / VS_POL
//   de           out  active video
//   line_start   out  one-clk pulse when hc loads 0
//   frame_start  out  one-clk pulse when hc and vc load 0
//   frame_cnt    out  frames completed; counts only when VTG_FRAME_CNT_EN is defined,
//                     otherwise tied to 0
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned HCW           = DEF_HCW,
    parameter int unsigned VCW           = DEF_VCW,
    parameter int unsigned CE_DIV        = DEF_CE_DIV,
    parameter int unsigned H_TOTAL       = DEF_H_TOTAL,
    parameter int unsigned H_ACTIVE      = DEF_H_ACTIVE,
    parameter int unsigned HS_START      = DEF_HS_START,
    parameter int unsigned HS_END        = DEF_HS_END,
    parameter int unsigned V_TOTAL_NTSC  = DEF_V_TOTAL_NTSC,
    parameter int unsigned V_ACTIVE_NTSC = DEF_V_ACTIVE_NTSC,
    parameter int unsigned VS_START_NTSC = DEF_VS_START_NTSC,
    parameter int unsigned VS_END_NTSC   = DEF_VS_END_NTSC,
    parameter int unsigned V_TOTAL_PAL   = DEF_V_TOTAL_PAL,
    parameter int unsigned V_ACTIVE_PAL  = DEF_V_ACTIVE_PAL,
    parameter int unsigned VS_START_PAL  = DEF_VS_START_PAL,
    parameter int unsigned VS_END_PAL    = DEF_VS_END_PAL,
    parameter logic        HS_POL        = 1'b1,
    parameter logic        VS_POL        = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           pal,
    input  logic           scandouble,
    output logic           ce_pix,
    output logic [HCW-1:0] hc,
    output logic [VCW-1:0] vc,
    output logic           HBlank,
    output logic           HSync,
    output logic           VBlank,
    output logic           VSync,
    output logic           de,
    output logic           line_start,
    output logic           frame_start,
    output logic [15:0]    frame_cnt
);

    typedef logic [HCW:0] hlim_t;
    typedef logic [VCW:0] vlim_t;

    localparam logic [HCW-1:0] H_LAST = HCW'(H_TOTAL - 1);

    // Elaboration-time sanity: the doubled line count must fit the vertical counter.
    if (CE_DIV < 2) begin : g_err_ce_div
        $error("video_timing_gen: CE_DIV must be at least 2");
    end
    if (H_TOTAL > (2 ** HCW)) begin : g_err_h_total
        $error("video_timing_gen: H_TOTAL does not fit in HCW bits");
    end
    if (scale_v(V_TOTAL_NTSC, 1'b1) > (2 ** VCW)) begin : g_err_v_ntsc
        $error("video_timing_gen: doubled NTSC line count overflows VCW bits");
    end
    if (scale_v(V_TOTAL_PAL, 1'b1) > (2 ** VCW)) begin : g_err_v_pal
        $error("video_timing_gen: doubled PAL line count overflows VCW bits");
    end

    // Pick the native value for the standard, then double it for scan-doubled modes.
    function automatic vlim_t vlimit(input vtg_mode_e m, input logic sd,
                                     input int unsigned ntsc_v, input int unsigned pal_v);
        return vlim_t'(scale_v((m == MODE_PAL) ? pal_v : ntsc_v, sd));
    endfunction

    logic           first_q;
    vtg_mode_e      mode_q, mode_d;
    logic           sd_q, sd_d;
    logic [HCW-1:0] hc_q, hc_d;
    logic [VCW-1:0] vc_q, vc_d;
    logic           h_last, v_last, wrap, latch;
    vlim_t          v_total_cur, v_active_nxt, vs_start_nxt, vs_end_nxt;
    logic           hblank_q, hblank_d;
    logic           hsync_q, hsync_d;
    logic           vblank_q, vblank_d;
    logic           vsync_q, vsync_d;
    logic           de_q, de_d;
    logic           line_start_q, line_start_d;
    logic           frame_start_q, frame_start_d;

    vtg_ce_div #(
        .CE_DIV (CE_DIV)
    ) u_ce_div (
        .clk     (clk),
        .reset   (reset),
        .restart (latch),
        .bypass  (sd_d),
        .ce      (ce_pix)
    );

    always_comb begin
        // Wrap test uses the mode of the frame being drawn.
        v_total_cur = vlimit(mode_q, sd_q, V_TOTAL_NTSC, V_TOTAL_PAL);
        h_last      = (hc_q == H_LAST);
        v_last      = ({1'b0, vc_q} == (v_total_cur - 1'b1));
        wrap        = ce_pix & h_last & v_last;
        latch       = first_q | wrap;

        mode_d = mode_q;
        sd_d   = sd_q;
        if (latch) begin
            mode_d = pal ? MODE_PAL : MODE_NTSC;
            sd_d   = scandouble;
        end

        hc_d = hc_q;
        vc_d = vc_q;
        if (ce_pix) begin
            if (h_last) begin
                hc_d = '0;
                vc_d = v_last ? '0 : vc_q + 1'b1;
            end else begin
                hc_d = hc_q + 1'b1;
            end
        end

        // Strobes decode the next position with the next mode, so line 0 after a mode
        // switch already sees the new vertical limits.
        v_active_nxt = vlimit(mode_d, sd_d, V_ACTIVE_NTSC, V_ACTIVE_PAL);
        vs_start_nxt = vlimit(mode_d, sd_d, VS_START_NTSC, VS_START_PAL);
        vs_end_nxt   = vlimit(mode_d, sd_d, VS_END_NTSC, VS_END_PAL);

        hblank_d = ({1'b0, hc_d} >= hlim_t'(H_ACTIVE));
        hsync_d  = (({1'b0, hc_d} >= hlim_t'(HS_START)) && ({1'b0, hc_d} < hlim_t'(HS_END)))
                   ? HS_POL : ~HS_POL;
        vblank_d = ({1'b0, vc_d} >= v_active_nxt);
        vsync_d  = (({1'b0, vc_d} >= vs_start_nxt) && ({1'b0, vc_d} < vs_end_nxt))
                   ? VS_POL : ~VS_POL;
        de_d     = ~hblank_d & ~vblank_d;

        line_start_d  = ce_pix & h_last;
        frame_start_d = wrap;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            first_q       <= 1'b1;
            mode_q        <= MODE_NTSC;
            sd_q          <= 1'b0;
            hc_q          <= '0;
            vc_q          <= '0;
            hblank_q      <= 1'b0;
            hsync_q       <= ~HS_POL;
            vblank_q      <= 1'b0;
            vsync_q       <= ~VS_POL;
            de_q          <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            first_q       <= 1'b0;
            mode_q        <= mode_d;
            sd_q          <= sd_d;
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            hblank_q      <= hblank_d;
            hsync_q       <= hsync_d;
            vblank_q      <= vblank_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

`ifdef VTG_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt_q <= '0;
        end else if (frame_start_d) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = '0;
`endif

    assign hc          = hc_q;
    assign vc          = vc_q;
    assign HBlank      = hblank_q;
    assign HSync       = hsync_q;
    assign VBlank      = vblank_q;
    assign VSync       = vsync_q;
    assign de          = de_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen on a shrunken raster. A frame-level model enumerates
// every pixel of each planned frame into a queue; a monitor pops one entry per ce_pix cycle.
module tb_video_timing_gen;

    localparam int unsigned CE_DIV = 2;
    localparam int unsigned HT  = 40, HA = 30, HSS = 32, HSE = 36;
    localparam int unsigned VTN = 20, VAN = 15, VSSN = 16, VSEN = 18;
    localparam int unsigned VTP = 24, VAP = 18, VSSP = 20, VSEP = 22;
`ifdef VTG_FRAME_CNT_EN
    localparam bit FCNT_EN = 1'b1;
`else
    localparam bit FCNT_EN = 1'b0;
`endif

    logic        clk = 1'b0, reset = 1'b1, pal = 1'b0, scandouble = 1'b0;
    logic        ce_pix, hblank, hsync, vblank, vsync, de, line_start, frame_start;
    logic [9:0]  hc, vc;
    logic [15:0] frame_cnt;
    logic        ce_pix_n, hblank_n, hsync_n, vblank_n, vsync_n, de_n, ls_n, fs_n;
    logic [9:0]  hc_n, vc_n;
    logic [15:0] frame_cnt_n;

    video_timing_gen #(
        .HCW(10), .VCW(10), .CE_DIV(CE_DIV), .H_TOTAL(HT), .H_ACTIVE(HA), .HS_START(HSS),
        .HS_END(HSE), .V_TOTAL_NTSC(VTN), .V_ACTIVE_NTSC(VAN), .VS_START_NTSC(VSSN),
        .VS_END_NTSC(VSEN), .V_TOTAL_PAL(VTP), .V_ACTIVE_PAL(VAP), .VS_START_PAL(VSSP),
        .VS_END_PAL(VSEP), .HS_POL(1'b1), .VS_POL(1'b1)
    ) u_dut (
        .clk(clk), .reset(reset), .pal(pal), .scandouble(scandouble), .ce_pix(ce_pix),
        .hc(hc), .vc(vc), .HBlank(hblank), .HSync(hsync), .VBlank(vblank), .VSync(vsync),
        .de(de), .line_start(line_start), .frame_start(frame_start), .frame_cnt(frame_cnt)
    );

    // Same raster with active-low syncs; only its sync pins are checked.
    video_timing_gen #(
        .HCW(10), .VCW(10), .CE_DIV(CE_DIV), .H_TOTAL(HT), .H_ACTIVE(HA), .HS_START(HSS),
        .HS_END(HSE), .V_TOTAL_NTSC(VTN), .V_ACTIVE_NTSC(VAN), .VS_START_NTSC(VSSN),
        .VS_END_NTSC(VSEN), .V_TOTAL_PAL(VTP), .V_ACTIVE_PAL(VAP), .VS_START_PAL(VSSP),
        .VS_END_PAL(VSEP), .HS_POL(1'b0), .VS_POL(1'b0)
    ) u_dut_pol0 (
        .clk(clk), .reset(reset), .pal(pal), .scandouble(scandouble), .ce_pix(ce_pix_n),
        .hc(hc_n), .vc(vc_n), .HBlank(hblank_n), .HSync(hsync_n), .VBlank(vblank_n),
        .VSync(vsync_n), .de(de_n), .line_start(ls_n), .frame_start(fs_n),
        .frame_cnt(frame_cnt_n)
    );

    initial forever #5 clk = ~clk;

    // flags = {hblank, hsync, vblank, vsync, de, line_start, frame_start, hsync_n, vsync_n}
    typedef struct packed {
        logic [9:0]  hc;
        logic [9:0]  vc;
        logic [8:0]  flags;
        logic [3:0]  gap;
        logic [15:0] fcnt;
    } pix_t;

    pix_t exp_q[$];
    int   n_cmp = 0, n_fail = 0, pix_consumed = 0;
    bit   checking = 1'b0;
    bit   plan_pal[8], plan_sd[8];

    function automatic int frame_len(input bit p, input bit s);
        return HT * (p ? VTP : VTN) * (s ? 2 : 1);
    endfunction

    // Every pixel of one frame, in raster order, from the timing rules directly.
    function automatic void push_frame(input bit p, input bit s, input bit first, input int fidx);
        int  m   = s ? 2 : 1;
        int  vt  = (p ? VTP : VTN) * m;
        int  va  = (p ? VAP : VAN) * m;
        int  vss = (p ? VSSP : VSSN) * m;
        int  vse = (p ? VSEP : VSEN) * m;
        bit  hb, hs_act, vb, vs_act, ls, fs;
        pix_t e;
        for (int v = 0; v < vt; v++) begin
            for (int h = 0; h < int'(HT); h++) begin
                hb     = (h >= int'(HA));
                hs_act = (h >= int'(HSS)) && (h < int'(HSE));
                vb     = (v >= va);
                vs_act = (v >= vss) && (v < vse);
                ls     = (h == 0) && !(first && v == 0);
                fs     = (h == 0) && (v == 0) && !first;
                e.hc    = 10'(h);
                e.vc    = 10'(v);
                e.flags = {hb, hs_act, vb, vs_act, !(hb || vb), ls, fs, !hs_act, !vs_act};
                e.gap   = s ? 4'd1 : 4'(CE_DIV);
                e.fcnt  = FCNT_EN ? 16'(fidx) : 16'd0;
                exp_q.push_back(e);
            end
        end
    endfunction

    // Monitor: one queue entry per ce_pix cycle; pulses and clk gaps are gathered per pixel.
    initial begin
        int   ls_cnt = 0, fs_cnt = 0, gap_cnt = 0;
        pix_t a, e;
        forever begin
            @(negedge clk);
            if (reset) begin
                ls_cnt = 0; fs_cnt = 0; gap_cnt = 0;
            end else begin
                gap_cnt++;
                if (line_start) ls_cnt++;
                if (frame_start) fs_cnt++;
                if (ce_pix) begin
                    if (checking) begin
                        a.hc    = hc;
                        a.vc    = vc;
                        a.flags = {hblank, hsync, vblank, vsync, de, (ls_cnt == 1),
                                   (fs_cnt == 1), hsync_n, vsync_n};
                        if (ls_cnt > 1 || fs_cnt > 1) a.flags[3:2] = 2'b11;
                        a.gap   = 4'(gap_cnt);
                        a.fcnt  = frame_cnt;
                        n_cmp++;
                        if (exp_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL unexpected_pixel: got hc=%0d vc=%0d, required none",
                                     hc, vc);
                        end else begin
                            e = exp_q.pop_front();
                            if (a !== e) begin
                                n_fail++;
                                $display({"FAIL pixel[%0d]: got hc=%0d vc=%0d flags=%b gap=%0d ",
                                          "fcnt=%0d, required hc=%0d vc=%0d flags=%b gap=%0d ",
                                          "fcnt=%0d"}, pix_consumed, a.hc, a.vc, a.flags,
                                         a.gap, a.fcnt, e.hc, e.vc, e.flags, e.gap, e.fcnt);
                            end
                            pix_consumed++;
                        end
                    end
                    ls_cnt = 0; fs_cnt = 0; gap_cnt = 0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic check_reset_values();
        chk("rst_hc", 32'(hc), 0);
        chk("rst_vc", 32'(vc), 0);
        chk("rst_ce_pix", 32'(ce_pix), 0);
        chk("rst_hblank", 32'(hblank), 0);
        chk("rst_vblank", 32'(vblank), 0);
        chk("rst_de", 32'(de), 0);
        chk("rst_line_start", 32'(line_start), 0);
        chk("rst_frame_start", 32'(frame_start), 0);
        chk("rst_frame_cnt", 32'(frame_cnt), 0);
        chk("rst_hsync", 32'(hsync), 0);
        chk("rst_vsync", 32'(vsync), 0);
        chk("rst_hsync_pol0", 32'(hsync_n), 1);
        chk("rst_vsync_pol0", 32'(vsync_n), 1);
    endtask

    task automatic wait_pix(input int target, output bit ok);
        int guard = 0;
        ok = 1'b1;
        while (pix_consumed < target) begin
            @(posedge clk);
            #1;
            guard++;
            if (guard > 6000) begin
                n_cmp++;
                n_fail++;
                $display("FAIL pixel_wait: got %0d pixels, required %0d", pix_consumed, target);
                ok = 1'b0;
                return;
            end
        end
    endtask

    // Runs nf planned frames from reset release. Pins are scrambled mid-frame and then set to
    // the next frame's mode before the wrap. With rst_end the last frame is cut by a reset.
    task automatic run_segment(input int nf, input bit rst_end);
        int base = 0, len, p1, p2;
        bit ok;
        exp_q.delete();
        pal          = plan_pal[0];
        scandouble   = plan_sd[0];
        push_frame(plan_pal[0], plan_sd[0], 1'b1, 0);
        pix_consumed = 0;
        checking     = 1'b1;
        @(negedge clk);
        #1 reset = 1'b0;
        for (int f = 0; f < nf; f++) begin
            len = frame_len(plan_pal[f], plan_sd[f]);
            if (f < nf - 1) begin
                p1 = $urandom_range(len / 2, 1);
                p2 = $urandom_range(len - 3, len / 2 + 1);
                wait_pix(base + p1, ok);
                if (!ok) break;
                pal        = ~plan_pal[f + 1];
                scandouble = 1'($urandom);
                wait_pix(base + p2, ok);
                if (!ok) break;
                pal        = plan_pal[f + 1];
                scandouble = plan_sd[f + 1];
                push_frame(plan_pal[f + 1], plan_sd[f + 1], 1'b0, f + 1);
                wait_pix(base + len, ok);
                if (!ok) break;
            end else if (rst_end) begin
                wait_pix(base + 5 * HT + $urandom_range(HT - 1, 0), ok);
                if (!ok) break;
                checking = 1'b0;
                @(posedge clk);
                #2 reset = 1'b1;
                #1 check_reset_values();
                exp_q.delete();
            end else begin
                wait_pix(base + len, ok);
                if (!ok) break;
            end
            base += len;
        end
        checking = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 check_reset_values();

        // NTSC native twice, then PAL native, PAL doubled, NTSC doubled, two random frames;
        // the final frame is cut by a mid-frame reset.
        plan_pal = '{0, 0, 1, 1, 0, 0, 0, 0};
        plan_sd  = '{0, 0, 0, 1, 1, 0, 0, 0};
        for (int i = 5; i < 7; i++) begin
            plan_pal[i] = 1'($urandom);
            plan_sd[i]  = 1'($urandom);
        end
        run_segment(7, 1'b1);

        repeat (4) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            plan_pal[i] = 1'($urandom);
            plan_sd[i]  = 1'($urandom);
        end
        run_segment(4, 1'b0);

        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
